// File: rtl/pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : pal_cfg_loader
// Brief    : Framed byte stream to PAL serial config chain, checksum-gated apply
// Revision : 1.0 - initial release
// ============================================================================
module pal_cfg_loader #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int P       = 13,
  parameter int CFG_LEN = 2*N*P + P*M
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_bit,
  output logic       cfg_valid,
  output logic       cfg_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int NBYTES = (CFG_LEN + 7) / 8;
  localparam int BCW    = $clog2(CFG_LEN + 1);
  localparam int YCW    = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_sreg;
  logic [7:0]       r_csum;
  logic [BCW-1:0]   r_bit_cnt;
  logic [YCW-1:0]   r_byte_cnt;
  logic             r_cfg_en;
  logic             r_err;
  logic             r_done;

  logic [BCW-1:0]   w_bit_inc;
  logic             w_chain_end;
  logic             w_byte_end;
  logic             w_accept;
  logic             w_sum_ok;

  // Bytes always start on 8-bit boundaries, so the low bits of the chain
  // counter double as the in-byte position.
  assign w_bit_inc   = r_bit_cnt + 1'b1;
  assign w_chain_end = (w_bit_inc == BCW'(CFG_LEN));
  assign w_byte_end  = (w_bit_inc[2:0] == 3'd0) || w_chain_end;

  assign in_ready  = ((r_state == S_LOAD) && (r_byte_cnt != YCW'(NBYTES))) ||
                     (r_state == S_CHECK);
  assign w_accept  = in_valid & in_ready & ~start;
  assign w_sum_ok  = (in_data == r_csum);

  assign cfg_valid = (r_state == S_SHIFT);
  assign cfg_bit   = (r_state == S_SHIFT) & r_sreg[0];
  assign busy      = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_CHECK);
  assign cfg_en    = r_cfg_en;
  assign err       = r_err;
  assign done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (w_accept) w_state_nxt = S_SHIFT;
        S_SHIFT: if (w_byte_end) w_state_nxt = w_chain_end ? S_CHECK : S_LOAD;
        S_CHECK: if (w_accept) w_state_nxt = w_sum_ok ? S_IDLE : S_ERR;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state    <= S_IDLE;
      r_sreg     <= '0;
      r_csum     <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_cfg_en   <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (start) begin
        // Abort or begin: the old config stays disabled while reloading.
        r_sreg     <= '0;
        r_csum     <= '0;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_cfg_en   <= 1'b0;
        r_err      <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_accept) begin
              r_sreg     <= in_data;
              r_csum     <= r_csum ^ in_data;
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          S_SHIFT: begin
            r_sreg    <= {1'b0, r_sreg[7:1]};
            r_bit_cnt <= w_bit_inc;
          end
          S_CHECK: begin
            if (w_accept) begin
              if (w_sum_ok) begin
                r_cfg_en <= 1'b1;
                r_done   <= 1'b1;
              end else begin
                r_err    <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pal_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pal_cfg_loader
// Brief    : Directed self-checking bench for pal_cfg_loader (12-bit and 260-bit chains)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pal_cfg_loader;

  logic       clk = 1'b0;
  logic       res;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sel;

  logic s_in_ready, s_cfg_bit, s_cfg_valid, s_cfg_en, s_busy, s_done, s_err;
  logic l_in_ready, l_cfg_bit, l_cfg_valid, l_cfg_en, l_busy, l_done, l_err;
  logic m_in_ready, m_cfg_bit, m_cfg_valid, m_cfg_en, m_busy, m_done, m_err;

  always #5 clk = ~clk;

  pal_cfg_loader #(.CFG_LEN(12)) u_dut_s (
    .clk(clk), .res(res), .start(start & ~sel), .in_data(in_data),
    .in_valid(in_valid & ~sel), .in_ready(s_in_ready), .cfg_bit(s_cfg_bit),
    .cfg_valid(s_cfg_valid), .cfg_en(s_cfg_en), .busy(s_busy), .done(s_done), .err(s_err)
  );

  pal_cfg_loader u_dut_l (
    .clk(clk), .res(res), .start(start & sel), .in_data(in_data),
    .in_valid(in_valid & sel), .in_ready(l_in_ready), .cfg_bit(l_cfg_bit),
    .cfg_valid(l_cfg_valid), .cfg_en(l_cfg_en), .busy(l_busy), .done(l_done), .err(l_err)
  );

  assign m_in_ready  = sel ? l_in_ready  : s_in_ready;
  assign m_cfg_bit   = sel ? l_cfg_bit   : s_cfg_bit;
  assign m_cfg_valid = sel ? l_cfg_valid : s_cfg_valid;
  assign m_cfg_en    = sel ? l_cfg_en    : s_cfg_en;
  assign m_busy      = sel ? l_busy      : s_busy;
  assign m_done      = sel ? l_done      : s_done;
  assign m_err       = sel ? l_err       : s_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Record every bit the PAL would shift in, plus done pulses.
  bit cap [0:4095];
  int ncap  = 0;
  int ndone = 0;
  always @(posedge clk) begin
    if (m_cfg_valid === 1'b1) begin
      if (ncap < 4096) cap[ncap] = m_cfg_bit;
      ncap++;
    end
    if (m_done === 1'b1) ndone++;
  end

  logic [7:0] fb [0:63];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bp);
    int n;
    bit hs;
    n  = 0;
    hs = 1'b0;
    in_data = b;
    while (!hs && n < 200) begin
      @(negedge clk);
      in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && m_in_ready) hs = 1'b1;
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!hs) check("hs_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] bits_since(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < 32; i++) v[i] = cap[base + i];
    return v;
  endfunction

  // Send a random 33-byte frame with correct checksum to the 260-bit DUT and verify the chain.
  task automatic big_frame(input string tag, input bit bp);
    int base, d0, nmis;
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < 33; i++) begin
      fb[i] = 8'($urandom);
      cs    = cs ^ fb[i];
    end
    base = ncap;
    d0   = ndone;
    pulse_start;
    for (int i = 0; i < 33; i++) send_byte(fb[i], bp);
    send_byte(cs, bp);
    tick(3);
    nmis = 0;
    for (int i = 0; i < 260; i++)
      if (cap[base + i] !== fb[i / 8][i % 8]) nmis++;
    check({tag, "_ncfg"}, 32'(ncap - base), 32'd260);
    check({tag, "_bits"}, 32'(nmis), 32'd0);
    check({tag, "_done"}, 32'(ndone - d0), 32'd1);
    check({tag, "_en"},   {31'd0, m_cfg_en}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base, d0;
    res = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; sel = 1'b0;

    // Reset held with in_valid high.
    repeat (2) begin
      @(negedge clk);
      check("rst_s", {27'd0, s_in_ready, s_cfg_valid, s_cfg_en, s_busy, s_err}, 32'd0);
      check("rst_l", {27'd0, l_in_ready, l_cfg_valid, l_cfg_en, l_busy, l_err}, 32'd0);
    end
    res = 1'b0; in_valid = 1'b0;
    tick(1);
    check("idle_ready", {31'd0, m_in_ready}, 32'd0);

    // Good 12-bit frame: A5, 03, checksum A6.
    base = ncap; d0 = ndone;
    pulse_start;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hA6, 1'b0);
    tick(3);
    check("s_ncfg", 32'(ncap - base), 32'd12);
    check("s_bits", bits_since(base, 12), 32'h3A5);
    check("s_done", 32'(ndone - d0), 32'd1);
    check("s_en_busy_err", {29'd0, m_cfg_en, m_busy, m_err}, 32'b100);
    tick(5);
    check("s_en_hold", {31'd0, m_cfg_en}, 32'd1);

    // Bad checksum.
    d0 = ndone;
    pulse_start;
    check("restart_en_drop", {31'd0, m_cfg_en}, 32'd0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    tick(3);
    check("bad_err", {31'd0, m_err}, 32'd1);
    check("bad_done", 32'(ndone - d0), 32'd0);
    check("bad_en_rdy_busy", {29'd0, m_cfg_en, m_in_ready, m_busy}, 32'd0);
    pulse_start;
    check("err_clear", {30'd0, m_err, m_in_ready}, 32'b01);

    // Start coincident with a valid byte: the byte is discarded.
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("coinc_state", {30'd0, m_busy, m_in_ready}, 32'b11);
    base = ncap; d0 = ndone;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h66, 1'b1);
    tick(3);
    check("bp_ncfg", 32'(ncap - base), 32'd12);
    check("bp_bits", bits_since(base, 12), 32'hA3C);
    check("bp_done", 32'(ndone - d0), 32'd1);
    check("bp_en", {31'd0, m_cfg_en}, 32'd1);

    // Default 260-bit chain.
    @(negedge clk) sel = 1'b1;
    big_frame("l1", 1'b0);

    // Abort mid-shift of byte 5.
    pulse_start;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    tick(2);
    check("abort_mid_shift", {31'd0, m_cfg_valid}, 32'd1);
    pulse_start;
    check("abort_state", {28'd0, m_cfg_en, m_in_ready, m_busy, m_cfg_valid}, 32'b0110);
    big_frame("l2", 1'b0);
    big_frame("l3", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
